// File: rtl/snitch_dmem_responder_pkg.sv
// Shared types for the Snitch data-memory responder.
//   dreq_t    : request  (addr, id, amo, write, data, strb)
//   dresp_t   : response (data, id, write, error)
//   amo_op_e  : atomic opcode carried in dreq_t.amo
//   resp_state_e : responder FSM states
package snitch_dmem_responder_pkg;

    localparam int unsigned MetaIdWidth = 4;
    localparam int unsigned AddrWidth   = 32;
    localparam int unsigned DataWidth   = 32;
    localparam int unsigned StrbWidth   = DataWidth / 8;

    typedef logic [MetaIdWidth-1:0] meta_id_t;

    typedef enum logic [3:0] {
        AMONone = 4'd0,
        AMOSwap = 4'd1,
        AMOAdd  = 4'd2,
        AMOAnd  = 4'd3,
        AMOOr   = 4'd4,
        AMOXor  = 4'd5,
        AMOMax  = 4'd6,
        AMOMaxu = 4'd7,
        AMOMin  = 4'd8,
        AMOMinu = 4'd9,
        AMOLR   = 4'd10,
        AMOSC   = 4'd11
    } amo_op_e;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        meta_id_t             id;
        amo_op_e              amo;
        logic                 write;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } dreq_t;

    typedef struct packed {
        logic [DataWidth-1:0] data;
        meta_id_t             id;
        logic                 write;
        logic                 error;
    } dresp_t;

    typedef enum logic {
        IDLE   = 1'b0,
        AMO_WR = 1'b1
    } resp_state_e;

endpackage

// File: rtl/snitch_dmem_responder_fifo.sv
// Fall-through response queue for the data-memory responder.
//   clk_i / rst_i : clock, synchronous active-high flush
//   push_i/data_i : enqueue a word
//   pop_i         : dequeue the head (only when !empty_o)
//   data_o        : head word; equals data_i in the same cycle when the queue is empty
//   empty_o       : no word visible at the head
//   usage_o       : number of words held in storage
module snitch_dmem_responder_fifo #(
    parameter int unsigned Width  = 8,
    parameter int unsigned Depth  = 2,
    localparam int unsigned UsageW = $clog2(Depth + 1),
    localparam int unsigned PtrW   = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [Width-1:0]  data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  data_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);

    logic [Width-1:0]  r_mem [Depth];
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW-1:0]   r_wr_ptr;
    logic [UsageW-1:0] r_usage;

    logic w_stored_empty;
    logic w_full;
    logic w_store;
    logic w_take;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_stored_empty = (r_usage == '0);
    assign w_full         = (r_usage == UsageW'(Depth));

    // An empty queue forwards the incoming word straight to the head; if it is
    // popped in the same cycle it never touches storage.
    assign data_o  = w_stored_empty ? data_i : r_mem[r_rd_ptr];
    assign empty_o = w_stored_empty && !push_i;
    assign usage_o = r_usage;

    assign w_store = push_i && !(w_stored_empty && pop_i) && (!w_full || pop_i);
    assign w_take  = pop_i && !w_stored_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_usage  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_take)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_store, w_take})
                2'b10:   r_usage <= r_usage + 1'b1;
                2'b01:   r_usage <= r_usage - 1'b1;
                default: r_usage <= r_usage;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_store) r_mem[r_wr_ptr] <= data_i;
    end

endmodule

// File: rtl/snitch_dmem_responder.sv
// Responder end of the Snitch core data interface. Services dreq_t requests
// against a local word-addressed SRAM, runs AMOs as read-modify-write, and
// returns one dresp_t per request in acceptance order (latency 1).
//   clk_i, rst_i         : clock, synchronous active-high reset
//   q_i/q_valid_i/q_ready_o : request channel
//   p_o/p_valid_o/p_ready_i : response channel
module snitch_dmem_responder
    import snitch_dmem_responder_pkg::*;
#(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned RespDepth = 2
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  dreq_t  q_i,
    input  logic   q_valid_i,
    output logic   q_ready_o,
    output dresp_t p_o,
    output logic   p_valid_o,
    input  logic   p_ready_i
);

    localparam int unsigned IdxW      = $clog2(NumWords);
    localparam int unsigned UsageW    = $clog2(RespDepth + 1);
    localparam logic [32:0] AddrLimit = 33'(NumWords) << 2;

    resp_state_e r_state;
    resp_state_e w_state_next;
    logic        r_pend;

    logic [DataWidth-1:0] r_mem [NumWords];
    logic [DataWidth-1:0] r_rdata;

    meta_id_t             r_resp_id;
    logic                 r_resp_write;
    logic                 r_resp_err;
    logic                 r_resp_hasdata;
    amo_op_e              r_amo_op;
    logic [DataWidth-1:0] r_amo_operand;
    logic [IdxW-1:0]      r_amo_idx;

    logic [IdxW-1:0]      w_idx;
    logic                 w_oor;
    logic                 w_is_none;
    logic                 w_is_rmw;
    logic                 w_is_store;
    logic                 w_req_err;
    logic                 w_space;
    logic                 w_accept_ok;
    logic                 w_req_fire;
    logic                 w_amo_we;
    logic [DataWidth-1:0] w_amo_new;

    dresp_t               w_push_resp;
    logic                 w_push;
    logic                 w_pop;
    logic [$bits(dresp_t)-1:0] w_fifo_data;
    logic                 w_fifo_empty;
    logic [UsageW-1:0]    w_usage;

    function automatic logic [DataWidth-1:0] amo_alu(
        input amo_op_e              op,
        input logic [DataWidth-1:0] old_val,
        input logic [DataWidth-1:0] opnd
    );
        logic signed [DataWidth-1:0] s_old;
        logic signed [DataWidth-1:0] s_opnd;
        s_old  = old_val;
        s_opnd = opnd;
        case (op)
            AMOSwap: return opnd;
            AMOAdd:  return old_val + opnd;
            AMOAnd:  return old_val & opnd;
            AMOOr:   return old_val | opnd;
            AMOXor:  return old_val ^ opnd;
            AMOMax:  return (s_old > s_opnd) ? old_val : opnd;
            AMOMaxu: return (old_val > opnd) ? old_val : opnd;
            AMOMin:  return (s_old < s_opnd) ? old_val : opnd;
            AMOMinu: return (old_val < opnd) ? old_val : opnd;
            default: return old_val;
        endcase
    endfunction

    // Request decode
    assign w_idx      = q_i.addr[2 +: IdxW];
    assign w_oor      = {1'b0, q_i.addr} >= AddrLimit;
    assign w_is_none  = (q_i.amo == AMONone);
    assign w_is_rmw   = (q_i.amo >= AMOSwap) && (q_i.amo <= AMOMinu);
    assign w_is_store = w_is_none && q_i.write;
    assign w_req_err  = w_oor || !(w_is_none || w_is_rmw);

    // Count both stored responses and the one being pushed this cycle, so an
    // accepted request is always guaranteed a FIFO slot when it responds.
    assign w_space     = (32'(w_usage) + 32'(r_pend)) < RespDepth;
    assign w_accept_ok = (r_state == IDLE) && !rst_i && w_space;
    assign q_ready_o   = w_accept_ok;
    assign w_req_fire  = q_valid_i && w_accept_ok;

    always_comb begin
        w_state_next = r_state;
        w_amo_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_fire && w_is_rmw && !w_oor) w_state_next = AMO_WR;
            end
            AMO_WR: begin
                // A reset landing here aborts the AMO before it writes back.
                w_amo_we     = !rst_i;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pend  <= w_req_fire;
        end
    end

    // Stage 0 -> 1: SRAM access and response metadata capture
    always_ff @(posedge clk_i) begin
        if (w_req_fire) begin
            r_rdata        <= r_mem[w_idx];
            r_resp_id      <= q_i.id;
            r_resp_write   <= w_is_store;
            r_resp_err     <= w_req_err;
            r_resp_hasdata <= !w_req_err && !w_is_store;
            r_amo_op       <= q_i.amo;
            r_amo_operand  <= q_i.data;
            r_amo_idx      <= w_idx;
            if (w_is_store && !w_req_err) begin
                for (int b = 0; b < StrbWidth; b++) begin
                    if (q_i.strb[b]) r_mem[w_idx][8*b +: 8] <= q_i.data[8*b +: 8];
                end
            end
        end
        if (w_amo_we) r_mem[r_amo_idx] <= w_amo_new;
    end

    // Stage 1: AMO writeback and response push
    assign w_amo_new = amo_alu(r_amo_op, r_rdata, r_amo_operand);

    always_comb begin
        w_push_resp       = '0;
        w_push_resp.data  = r_resp_hasdata ? r_rdata : '0;
        w_push_resp.id    = r_resp_id;
        w_push_resp.write = r_resp_write;
        w_push_resp.error = r_resp_err;
    end

    assign w_push = r_pend && !rst_i;
    assign w_pop  = p_valid_o && p_ready_i;

    snitch_dmem_responder_fifo #(
        .Width ($bits(dresp_t)),
        .Depth (RespDepth)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (w_push_resp),
        .pop_i   (w_pop),
        .data_o  (w_fifo_data),
        .empty_o (w_fifo_empty),
        .usage_o (w_usage)
    );

    assign p_valid_o = !w_fifo_empty && !rst_i;
    assign p_o       = p_valid_o ? dresp_t'(w_fifo_data) : '0;

endmodule

// File: tb/tb_snitch_dmem_responder.sv
module tb_snitch_dmem_responder;
    import snitch_dmem_responder_pkg::*;

    localparam int unsigned NumWords  = 1024;
    localparam int unsigned RespDepth = 2;

    logic   clk = 1'b0;
    logic   rst;
    dreq_t  q;
    logic   q_valid;
    logic   q_ready;
    dresp_t p;
    logic   p_valid;
    logic   p_ready;

    always #5 clk = ~clk;

    snitch_dmem_responder #(
        .NumWords  (NumWords),
        .RespDepth (RespDepth)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .q_i       (q),
        .q_valid_i (q_valid),
        .q_ready_o (q_ready),
        .p_o       (p),
        .p_valid_o (p_valid),
        .p_ready_i (p_ready)
    );

    int          n_checks   = 0;
    int          n_fail     = 0;
    int          n_accepted = 0;
    string       cur_tag    = "init";
    bit          rand_bp    = 1'b0;
    dresp_t      exp_q[$];
    logic [31:0] model_mem[int];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_amo(input amo_op_e op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            AMOSwap: return b;
            AMOAdd:  return a + b;
            AMOAnd:  return a & b;
            AMOOr:   return a | b;
            AMOXor:  return a ^ b;
            AMOMax:  return ($signed(a) >= $signed(b)) ? a : b;
            AMOMaxu: return (a >= b) ? a : b;
            AMOMin:  return ($signed(a) <= $signed(b)) ? a : b;
            AMOMinu: return (a <= b) ? a : b;
            default: return a;
        endcase
    endfunction

    task automatic predict(input dreq_t r);
        dresp_t      e;
        int          idx;
        logic [31:0] w;
        e       = '0;
        e.id    = r.id;
        idx     = int'(r.addr >> 2);
        if (r.addr >= NumWords * 4 || int'(r.amo) > 9) begin
            e.error = 1'b1;
            e.write = r.write && (r.amo == AMONone);
        end else if (r.amo == AMONone && r.write) begin
            w = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (r.strb[b]) w[8*b +: 8] = r.data[8*b +: 8];
            model_mem[idx] = w;
            e.write = 1'b1;
        end else if (r.amo == AMONone) begin
            e.data = model_mem[idx];
        end else begin
            e.data = model_mem[idx];
            model_mem[idx] = model_amo(r.amo, model_mem[idx], r.data);
        end
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] op,
                        input logic wr, input logic [31:0] data, input logic [3:0] strb);
        dreq_t r;
        r.addr  = addr;
        r.id    = id;
        r.amo   = amo_op_e'(op);
        r.write = wr;
        r.data  = data;
        r.strb  = strb;
        q       = r;
        q_valid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (q_ready) begin
                predict(r);
                n_accepted++;
                @(posedge clk);
                #1;
                q_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk({"accept_timeout_", cur_tag}, 64'(q_ready), 64'd1);
        q_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        chk({"drain_", cur_tag}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: every consumed response is compared with the scoreboard head.
    initial begin
        dresp_t e;
        forever begin
            @(negedge clk);
            if (p_valid && p_ready) begin
                if (exp_q.size() == 0) begin
                    chk({"resp_underflow_", cur_tag}, 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({"resp_", cur_tag}, 64'(p), 64'(e));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) p_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int          base;
        logic [31:0] saved;
        rst     = 1'b1;
        q_valid = 1'b0;
        q       = '0;
        p_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_q_ready", 64'(q_ready), 64'd0);
        chk("rst_p_valid", 64'(p_valid), 64'd0);
        chk("rst_p_o", 64'(p), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_q_ready", 64'(q_ready), 64'd1);
        @(posedge clk);
        #1;

        cur_tag = "store_load";
        send(32'h10, 4'd3, 4'd0, 1'b1, 32'hDEADBEEF, 4'hF);
        send(32'h10, 4'd5, 4'd0, 1'b0, 32'h0, 4'h0);
        drain();

        cur_tag = "strobe";
        send(32'h14, 4'd1, 4'd0, 1'b1, 32'h11223344, 4'hF);
        send(32'h14, 4'd2, 4'd0, 1'b1, 32'hAAAAAAAA, 4'h2);
        send(32'h15, 4'd3, 4'd0, 1'b0, 32'h0, 4'h0);
        drain();

        cur_tag = "amo_add";
        send(32'h18, 4'd1, 4'd0, 1'b1, 32'h7, 4'hF);
        send(32'h18, 4'd2, 4'd2, 1'b0, 32'h3, 4'h0);
        @(negedge clk);
        chk("amo_wr_q_ready", 64'(q_ready), 64'd0);
        @(posedge clk);
        #1;
        send(32'h18, 4'd3, 4'd0, 1'b0, 32'h0, 4'h0);
        drain();

        cur_tag = "amo_min";
        send(32'h1C, 4'd4, 4'd0, 1'b1, 32'hFFFFFFFF, 4'hF);
        send(32'h1C, 4'd5, 4'd8, 1'b0, 32'h1, 4'h0);
        send(32'h1C, 4'd6, 4'd0, 1'b0, 32'h0, 4'h0);
        send(32'h20, 4'd7, 4'd0, 1'b1, 32'hFFFFFFFF, 4'hF);
        send(32'h20, 4'd8, 4'd9, 1'b0, 32'h1, 4'h0);
        send(32'h20, 4'd9, 4'd0, 1'b0, 32'h0, 4'h0);
        drain();

        cur_tag = "amo_mix";
        send(32'h24, 4'd0, 4'd0, 1'b1, 32'h8000_00F0, 4'hF);
        for (int op = 1; op <= 9; op++) begin
            send(32'h24, 4'(op), 4'(op), 1'b0, 32'h0F0F_1234 ^ (32'(op) << 28), 4'h0);
            send(32'h24, 4'd15, 4'd0, 1'b0, 32'h0, 4'h0);
        end
        drain();

        cur_tag = "errors";
        send(NumWords * 4, 4'd7, 4'd0, 1'b0, 32'h0, 4'h0);
        send(NumWords * 4 + 4, 4'd6, 4'd0, 1'b1, 32'h12345678, 4'hF);
        send(32'h10, 4'd5, 4'd10, 1'b0, 32'h55555555, 4'h0);
        send(32'h10, 4'd4, 4'd11, 1'b1, 32'h66666666, 4'hF);
        send(32'h10, 4'd3, 4'd12, 1'b0, 32'h77777777, 4'h0);
        send(32'h10, 4'd2, 4'd0, 1'b0, 32'h0, 4'h0);
        drain();

        cur_tag = "backpressure";
        base    = n_accepted;
        p_ready = 1'b0;
        fork
            begin
                send(32'h10, 4'd8, 4'd0, 1'b0, 32'h0, 4'h0);
                send(32'h14, 4'd9, 4'd0, 1'b0, 32'h0, 4'h0);
                send(32'h18, 4'd10, 4'd0, 1'b0, 32'h0, 4'h0);
                send(32'h1C, 4'd11, 4'd0, 1'b0, 32'h0, 4'h0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("bp_accepted", 64'(n_accepted - base), 64'(RespDepth));
                chk("bp_q_ready", 64'(q_ready), 64'd0);
                chk("bp_head_id", 64'(p.id), 64'd8);
                @(posedge clk);
                #1;
                p_ready = 1'b1;
            end
        join
        drain();

        cur_tag = "random";
        for (int k = 0; k < 8; k++)
            send(32'h40 + 32'(4 * k), 4'(k), 4'd0, 1'b1, $urandom, 4'hF);
        rand_bp = 1'b1;
        for (int k = 0; k < 40; k++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a   = 32'h40 + 32'(4 * $urandom_range(0, 7));
            if (sel < 4)      send(a, 4'(k), 4'd0, 1'b0, 32'h0, 4'h0);
            else if (sel < 7) send(a, 4'(k), 4'd0, 1'b1, $urandom, 4'($urandom_range(1, 15)));
            else              send(a, 4'(k), 4'($urandom_range(1, 9)), 1'b0, $urandom, 4'h0);
        end
        drain();
        rand_bp = 1'b0;
        p_ready = 1'b1;

        cur_tag = "reset_amo";
        send(32'h30, 4'd1, 4'd0, 1'b1, 32'h5, 4'hF);
        drain();
        saved = model_mem[12];
        send(32'h30, 4'd6, 4'd2, 1'b0, 32'h1, 4'h0);
        rst = 1'b1;
        void'(exp_q.pop_back());
        model_mem[12] = saved;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_amo_p_valid", 64'(p_valid), 64'd0);
        chk("rst_amo_q_ready", 64'(q_ready), 64'd1);
        @(posedge clk);
        #1;
        send(32'h30, 4'd7, 4'd0, 1'b0, 32'h0, 4'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
